// File: rtl/main_mem_responder_pkg.sv
// Shared state encoding and default geometry for the main-memory responder.
package main_mem_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT        = 3'd1,
        ST_READ_BURST  = 3'd2,
        ST_WRITE_BURST = 3'd3,
        ST_WRITE_ACK   = 3'd4
    } state_e;

    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_MEM_WORDS  = 1024;
    localparam int DEF_LATENCY    = 3;

    // States in which a response beat is driven to the cache.
    function automatic logic is_beat_state(input state_e s);
        return (s == ST_READ_BURST) || (s == ST_WRITE_ACK);
    endfunction

endpackage

// File: rtl/main_mem_responder_array.sv
// Single-port word RAM: synchronous write, registered read that returns 0
// whenever no read is issued, so its output register can drive rsp_data.
module main_mem_array #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [WORDS];
    logic [31:0] rdata_q;

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register, cleared when idle so non-read beats carry zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 32'h0000_0000;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end else begin
            rdata_q <= 32'h0000_0000;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/main_mem_responder.sv
// Behavioural main memory answering cache line refills and writebacks.
// Optional MAIN_MEM_ERR_EN adds rsp_err and out-of-range request detection.
module main_mem_responder
    import main_mem_responder_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int MEM_WORDS  = DEF_MEM_WORDS,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_last
`ifdef MAIN_MEM_ERR_EN
    ,
    output logic        rsp_err
`endif
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int OW = $clog2(LINE_WORDS);
    localparam int LB = AW - OW;
    localparam int CW = (LATENCY > 32'sd1) ? $clog2(LATENCY) : 32'sd1;
    localparam logic [OW-1:0] OFF_LAST = OW'(LINE_WORDS - 32'sd1);
    localparam logic [CW-1:0] LAT_INIT = CW'((LATENCY > 32'sd0) ? LATENCY - 32'sd1 : 32'sd0);

    state_e          state_q, state_d;
    logic [LB-1:0]   line_q, line_d;
    logic [OW-1:0]   off_q, off_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic            err_q, err_d;
    logic            req_ready_q, wdata_ready_q, rsp_valid_q, rsp_last_q;
    logic [LB-1:0]   req_line_s;
    logic            req_err_s;
    logic            mem_we_s, mem_re_s;
    logic [AW-1:0]   mem_addr_s;
    logic            unused_addr_s;

    assign req_line_s    = req_addr[AW+1:OW+2];
    assign unused_addr_s = ^{req_addr[31:AW+2], req_addr[OW+1:0]};

`ifdef MAIN_MEM_ERR_EN
    assign req_err_s = |req_addr[31:AW+2];
`else
    assign req_err_s = 1'b0;
`endif

    // Next-state, address sequencing and RAM strobes.
    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        off_d    = off_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        err_d    = err_q;
        mem_we_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d   = req_we;
                    line_d = req_line_s;
                    err_d  = req_err_s;
                    off_d  = {OW{1'b0}};
                    cnt_d  = LAT_INIT;
                    if (req_we) begin
                        state_d = ST_WRITE_BURST;
                    end else if (LATENCY == 32'sd0) begin
                        state_d = ST_READ_BURST;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = we_q ? ST_WRITE_ACK : ST_READ_BURST;
                    off_d   = {OW{1'b0}};
                end else begin
                    cnt_d = cnt_q - CW'(1'b1);
                end
            end
            ST_READ_BURST: begin
                if (off_q == OFF_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    off_d = off_q + OW'(1'b1);
                end
            end
            ST_WRITE_BURST: begin
                if (wdata_valid && wdata_ready_q) begin
                    mem_we_s = !err_q;
                    if (off_q == OFF_LAST) begin
                        cnt_d   = LAT_INIT;
                        state_d = (LATENCY == 32'sd0) ? ST_WRITE_ACK : ST_WAIT;
                    end else begin
                        off_d = off_q + OW'(1'b1);
                    end
                end else begin
                    state_d = ST_WRITE_BURST;
                end
            end
            ST_WRITE_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reads are issued for the beat of the coming cycle, so the RAM output
    // register lines up with rsp_valid.
    assign mem_re_s   = (state_d == ST_READ_BURST) && !err_d;
    assign mem_addr_s = mem_we_s ? {line_q, off_q} : {line_d, off_d};

    // FSM and transaction context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            line_q  <= {LB{1'b0}};
            off_q   <= {OW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    // Output flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready_q   <= 1'b0;
            wdata_ready_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_last_q    <= 1'b0;
        end else begin
            req_ready_q   <= (state_d == ST_IDLE);
            wdata_ready_q <= (state_d == ST_WRITE_BURST);
            rsp_valid_q   <= is_beat_state(state_d);
            rsp_last_q    <= (state_d == ST_WRITE_ACK) ||
                             ((state_d == ST_READ_BURST) && (off_d == OFF_LAST));
        end
    end

`ifdef MAIN_MEM_ERR_EN
    logic rsp_err_q;

    // Error flag accompanies every beat of an out-of-range transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= err_d && is_beat_state(state_d);
        end
    end

    assign rsp_err = rsp_err_q;
`endif

    main_mem_array #(
        .WORDS (MEM_WORDS)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we_s),
        .re_i    (mem_re_s),
        .addr_i  (mem_addr_s),
        .wdata_i (wdata),
        .rdata_o (rsp_data)
    );

    assign req_ready   = req_ready_q;
    assign wdata_ready = wdata_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_last    = rsp_last_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench: one responder with LATENCY=3 and one with LATENCY=0.
module tb_main_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, wdata_valid;
    logic [31:0] req_addr, wdata;
    logic        req_ready, wdata_ready, rsp_valid, rsp_last;
    logic [31:0] rsp_data;
    logic        z_req_valid, z_req_we, z_wdata_valid;
    logic [31:0] z_req_addr, z_wdata;
    logic        z_req_ready, z_wdata_ready, z_rsp_valid, z_rsp_last;
    logic [31:0] z_rsp_data;
`ifdef MAIN_MEM_ERR_EN
    logic        rsp_err, z_rsp_err;
`endif

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    main_mem_responder #(.LINE_WORDS(4), .MEM_WORDS(1024), .LATENCY(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last)
`ifdef MAIN_MEM_ERR_EN
        , .rsp_err(rsp_err)
`endif
    );

    main_mem_responder #(.LINE_WORDS(4), .MEM_WORDS(1024), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we), .req_addr(z_req_addr),
        .wdata_valid(z_wdata_valid), .wdata_ready(z_wdata_ready), .wdata(z_wdata),
        .rsp_valid(z_rsp_valid), .rsp_data(z_rsp_data), .rsp_last(z_rsp_last)
`ifdef MAIN_MEM_ERR_EN
        , .rsp_err(z_rsp_err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Full-line write on the LATENCY=3 instance with ack timing checks.
    task automatic wr_line(input logic [31:0] addr, input logic [127:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = addr;
        tick();
        req_valid = 1'b0;
        check("wr_wready_on", {31'd0, wdata_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            wdata_valid = 1'b1; wdata = d[32*i +: 32];
            tick();
        end
        wdata_valid = 1'b0;
        check("wr_wready_off", {31'd0, wdata_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("wr_wait_quiet", {31'd0, rsp_valid}, 32'd0);
            if (i < 2) tick();
        end
        tick();
        check("wr_ack_valid", {31'd0, rsp_valid}, 32'd1);
        check("wr_ack_last", {31'd0, rsp_last}, 32'd1);
        check("wr_ack_data", rsp_data, 32'd0);
        tick();
        check("wr_done_valid", {31'd0, rsp_valid}, 32'd0);
        check("wr_done_ready", {31'd0, req_ready}, 32'd1);
    endtask

    // Full-line read on the LATENCY=3 instance; err_exp selects zero data.
    task automatic rd_line(input logic [31:0] addr, input logic [127:0] d, input logic err_exp);
        logic [31:0] exp_w;
        req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
        tick();
        req_valid = 1'b0;
        check("rd_ready_low", {31'd0, req_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("rd_wait_quiet", {31'd0, rsp_valid}, 32'd0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            exp_w = err_exp ? 32'd0 : d[32*i +: 32];
            check("rd_beat_valid", {31'd0, rsp_valid}, 32'd1);
            check("rd_beat_data", rsp_data, exp_w);
            check("rd_beat_last", {31'd0, rsp_last}, (i == 3) ? 32'd1 : 32'd0);
`ifdef MAIN_MEM_ERR_EN
            check("rd_beat_err", {31'd0, rsp_err}, {31'd0, err_exp});
`endif
            tick();
        end
        check("rd_end_valid", {31'd0, rsp_valid}, 32'd0);
        check("rd_end_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] line40, line00, line80, line100;
        logic [6:0]   pat;
        int           k;
        line40  = {32'h44, 32'h33, 32'h22, 32'h11};
        line00  = {32'hA5A5_0004, 32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001};
        line80  = {32'hC0DE_0004, 32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001};
        line100 = {32'h0BAD_F00D, 32'h1234_5678, 32'hCAFE_BABE, 32'hDEAD_0001};
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; wdata_valid = 1'b0; wdata = 32'd0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'd0; z_wdata_valid = 1'b0; z_wdata = 32'd0;

        tick(); tick();
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_wdata_ready", {31'd0, wdata_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_last", {31'd0, rsp_last}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        rst_n = 1'b1;
        check("rel_ready_low", {31'd0, req_ready}, 32'd0);
        tick();
        check("rel_ready_high", {31'd0, req_ready}, 32'd1);

        wr_line(32'h0000_0040, line40);
        rd_line(32'h0000_004C, line40, 1'b0);
        wr_line(32'h0000_0000, line00);

        // Gapped writeback to line 0x80: valid pattern 1,0,0,1,1,0,1.
        pat = 7'b1011001;
        k = 0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0080;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            wdata_valid = pat[i];
            wdata = pat[i] ? line80[32*k +: 32] : 32'hDEAD_BEEF;
            tick();
            if (pat[i]) k++;
            if (i == 5) check("gap_wready_held", {31'd0, wdata_ready}, 32'd1);
        end
        check("gap_wready_off", {31'd0, wdata_ready}, 32'd0);
        wdata_valid = 1'b1; wdata = 32'hBAAD_BAAD;
        check("gap_wait0", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("gap_wait1", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("gap_wait2", {31'd0, rsp_valid}, 32'd0);
        wdata_valid = 1'b0;
        tick();
        check("gap_ack_valid", {31'd0, rsp_valid}, 32'd1);
        check("gap_ack_last", {31'd0, rsp_last}, 32'd1);
        tick();
        check("gap_done_ready", {31'd0, req_ready}, 32'd1);
        rd_line(32'h0000_0080, line80, 1'b0);

        // Reset during the second read beat.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0040;
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick(); tick();
        check("mid_beat2_data", rsp_data, 32'h22);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_data", rsp_data, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("mid_rel_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rel_valid", {31'd0, rsp_valid}, 32'd0);
        rd_line(32'h0000_0040, line40, 1'b0);

        // LATENCY=0 instance: write then read.
        z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h0000_0100;
        tick();
        z_req_valid = 1'b0;
        check("z_wready", {31'd0, z_wdata_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            z_wdata_valid = 1'b1; z_wdata = line100[32*i +: 32];
            tick();
        end
        z_wdata_valid = 1'b0;
        check("z_ack_valid", {31'd0, z_rsp_valid}, 32'd1);
        check("z_ack_last", {31'd0, z_rsp_last}, 32'd1);
        check("z_ack_data", z_rsp_data, 32'd0);
        tick();
        check("z_ack_done", {31'd0, z_req_ready}, 32'd1);
        z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 32'h0000_0104;
        tick();
        z_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("z_rd_ready_low", {31'd0, z_req_ready}, 32'd0);
            check("z_rd_valid", {31'd0, z_rsp_valid}, 32'd1);
            check("z_rd_data", z_rsp_data, line100[32*i +: 32]);
            check("z_rd_last", {31'd0, z_rsp_last}, (i == 3) ? 32'd1 : 32'd0);
            tick();
        end
        check("z_rd_ready_back", {31'd0, z_req_ready}, 32'd1);
        check("z_rd_valid_off", {31'd0, z_rsp_valid}, 32'd0);

        // Out-of-range address: wraps to line 0 or reports an error.
`ifdef MAIN_MEM_ERR_EN
        rd_line(32'h0000_1000, line00, 1'b1);
`else
        rd_line(32'h0000_1000, line00, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
